axi4_write_dma: RTL and testbench
=================================

AXI4_WRITE_DMA -- requirements
Module: axi4_write_dma

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 128, AXI W data width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 1, AXI ID width.
REQ-004 SHALL have parameter AXIS_DATA_WIDTH, default 32, input stream width; AXI_DATA_WIDTH is an integer multiple of it.
REQ-005 SHALL have parameter MAX_BURST_LEN, default 256, maximum beats per AW burst.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 SHALL have the clock port: aclk  in  1  single clock, all logic on rising edge.
REQ-008 SHALL have the reset port: areset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have the control ports: start_addr  in  AXI_ADDR_WIDTH, AXI-beat aligned; transfer_length  in  32, bytes, multiple of AXIS_DATA_WIDTH/8; start  in  1; done  out  1; error  out  1.
REQ-010 SHALL have the AW channel: m_axi_awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awlock, awcache[3:0], awprot[2:0], awqos[3:0], awvalid  out; awready  in.
REQ-011 SHALL have the W channel: m_axi_wdata  out  AXI_DATA_WIDTH; wstrb  out  AXI_DATA_WIDTH/8; wlast, wvalid  out; wready  in.
REQ-012 SHALL have the B channel: m_axi_bid  in  AXI_ID_WIDTH; bresp  in  2; bvalid  in; bready  out.
REQ-013 SHALL have the AXI-Stream slave: s_axis_tdata  in  AXIS_DATA_WIDTH; s_axis_tvalid  in; s_axis_tlast  in; s_axis_tready  out.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE_WRITE, SEND_DATA, WAIT_RESP, DONE_STATE.
REQ-015 IDLE: on start=1, SHALL latch start_addr/transfer_length and go to ISSUE_WRITE; if transfer_length=0, SHALL go directly to DONE_STATE with no AXI traffic.
REQ-016 ISSUE_WRITE: SHALL drive awlen = min(ceil(bytes_remaining/AXI_BYTES), MAX_BURST_LEN)-1, awsize=log2(AXI_BYTES), awburst=INCR, awcache=4'b0011, awid/awlock/awprot/awqos=0, awvalid=1; SHALL hold all AW fields stable until awready, then go to SEND_DATA.
REQ-017 SEND_DATA: SHALL pack AXIS words into one W beat, word 0 at LSBs; s_axis_tready=1 only while the pack register is not full and no W beat is pending.
REQ-018 A W beat SHALL be presented (wvalid=1) the cycle after its last word is accepted; wdata/wstrb/wlast SHALL be stable until wready.
REQ-019 wstrb SHALL be all-ones for full beats; for the final partial beat, only lanes of received words are set and unfilled data lanes are zero.
REQ-020 wlast SHALL be 1 exactly on beat awlen of the burst; after that handshake, go to WAIT_RESP with bready=1.
REQ-021 WAIT_RESP: on bvalid, if bresp!=2'b00 SHALL set error and go to DONE_STATE; else decrement bytes_remaining and advance address by beats×AXI_BYTES, then go to ISSUE_WRITE if bytes_remaining>0, else DONE_STATE.
REQ-022 Only one burst SHALL be outstanding; bursts are not split at 4 KB boundaries.
REQ-023 DONE_STATE: done=1, tready=0; SHALL stay until start=0, then return to IDLE, clearing done and error.
REQ-024 bytes_remaining arithmetic SHALL be 32-bit and SHALL never underflow.

Reset
REQ-025 On areset=1, asynchronously: state=IDLE; done, error, awvalid, wvalid, wlast, bready, s_axis_tready=0; counters and pack register=0.
REQ-026 Reset mid-burst SHALL abandon the transfer without completing the W burst; the next start after release SHALL behave as a fresh transfer.

Configuration
REQ-027 With macro AXI4_WRITE_DMA_TLAST_CHECK_EN defined, s_axis_tlast=1 on any word but the final one, or 0 on the final word, SHALL set error (reported at DONE_STATE) while the transfer completes by byte count; without it, s_axis_tlast SHALL be ignored.

Verification
REQ-028 start_addr=0x1000, length=64 -> one AW awlen=3, four W beats, wstrb=16'hFFFF, wlast on 4th, bresp OKAY -> done=1, error=0.
REQ-029 length=8192 -> AW at 0x0 awlen=255, then AW at 0x1000 awlen=255 issued only after first B response.
REQ-030 length=40 (10 words) -> awlen=2; third beat wstrb=16'h00FF, wdata[127:64]=0.
REQ-031 length=8192, first bresp=2'b10 -> error=1, done=1, no second AW.
REQ-032 Random wready/awready/bvalid stalls and tvalid gaps, length=256 -> written data equals stream words in order.
REQ-033 areset pulsed during beat 2 of a 4-beat burst -> all outputs at reset values; new start with length=16 completes correctly.

Source files
------------

// File: rtl/axi4_write_dma.sv
// axi4_write_dma: moves an AXI-Stream word sequence into memory using AXI4
// INCR write bursts, one burst outstanding at a time.
// Optional build macro AXI4_WRITE_DMA_TLAST_CHECK_EN: flags an error when
// s_axis_tlast does not mark exactly the final word of the transfer.
module axi4_write_dma #(
  parameter int unsigned AXI_ADDR_WIDTH  = 64,
  parameter int unsigned AXI_DATA_WIDTH  = 128,
  parameter int unsigned AXI_ID_WIDTH    = 1,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST_LEN   = 256
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ADDR_WIDTH-1:0]     start_addr,
  input  logic [31:0]                   transfer_length,
  input  logic                          start,
  output logic                          done,
  output logic                          error,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic [3:0]                    m_axi_awqos,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready
);

  localparam int unsigned AXI_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int unsigned WORD_BYTES = AXIS_DATA_WIDTH / 8;
  localparam int unsigned WORDS      = AXI_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int unsigned SIZE_LOG2  = $clog2(AXI_BYTES);
  localparam int unsigned WCNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WRITE,
    SEND_DATA,
    WAIT_RESP,
    DONE_STATE
  } state_t;

  state_t state, state_next;

  logic [AXI_ADDR_WIDTH-1:0]   addr_r;
  logic [AXI_ADDR_WIDTH-1:0]   span_r;
  logic [31:0]                 bytes_rem;
  logic [31:0]                 burst_bytes_r;
  logic [31:0]                 burst_left;
  logic [7:0]                  len_r;
  logic [7:0]                  beat_cnt;
  logic [WCNT_W-1:0]           word_cnt;
  logic [AXI_DATA_WIDTH-1:0]   pack_r;
  logic [AXI_DATA_WIDTH/8-1:0] strb_r;
  logic                        wvalid_r;
  logic                        error_r;

  logic [32:0] beats_need, beats_c;
  logic [63:0] span_c;
  logic [31:0] burst_bytes_c;
  logic [31:0] rem_after;
  logic        accept, beat_close, w_hs;
  logic        unused_inputs;

  assign unused_inputs = ^{m_axi_bid, s_axis_tlast};

  // Burst sizing: beats = min(ceil(bytes_rem / AXI_BYTES), MAX_BURST_LEN);
  // the byte count is clamped to bytes_rem so the subtraction cannot underflow.
  always_comb begin
    beats_need    = ({1'b0, bytes_rem} + 33'(AXI_BYTES - 1)) >> SIZE_LOG2;
    beats_c       = (beats_need > 33'(MAX_BURST_LEN)) ? 33'(MAX_BURST_LEN) : beats_need;
    span_c        = 64'(beats_c) << SIZE_LOG2;
    burst_bytes_c = (span_c > 64'(bytes_rem)) ? bytes_rem : span_c[31:0];
    rem_after     = bytes_rem - burst_bytes_r;
  end

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign beat_close = accept && ((word_cnt == WCNT_W'(WORDS - 1)) ||
                                 (burst_left == 32'(WORD_BYTES)));
  assign w_hs       = wvalid_r && m_axi_wready;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and channel control outputs.
  always_comb begin
    state_next     = state;
    m_axi_awvalid  = 1'b0;
    m_axi_bready   = 1'b0;
    done           = 1'b0;
    s_axis_tready  = 1'b0;
    m_axi_awid     = '0;
    m_axi_awaddr   = addr_r;
    m_axi_awlen    = beats_c[7:0] - 8'd1;
    m_axi_awsize   = 3'(SIZE_LOG2);
    m_axi_awburst  = 2'b01;
    m_axi_awlock   = 1'b0;
    m_axi_awcache  = 4'b0011;
    m_axi_awprot   = '0;
    m_axi_awqos    = '0;
    m_axi_wvalid   = wvalid_r;
    m_axi_wdata    = pack_r;
    m_axi_wstrb    = strb_r;
    m_axi_wlast    = wvalid_r && (beat_cnt == len_r);
    error          = error_r;
    case (state)
      IDLE: begin
        if (start) state_next = (transfer_length == '0) ? DONE_STATE : ISSUE_WRITE;
      end
      ISSUE_WRITE: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = SEND_DATA;
      end
      SEND_DATA: begin
        s_axis_tready = !wvalid_r && (burst_left != '0);
        if (w_hs && m_axi_wlast) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00)  state_next = DONE_STATE;
          else if (rem_after != '0) state_next = ISSUE_WRITE;
          else                       state_next = DONE_STATE;
        end
      end
      DONE_STATE: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transfer bookkeeping, beat packing and error capture.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_r        <= '0;
      span_r        <= '0;
      bytes_rem     <= '0;
      burst_bytes_r <= '0;
      burst_left    <= '0;
      len_r         <= '0;
      beat_cnt      <= '0;
      word_cnt      <= '0;
      pack_r        <= '0;
      strb_r        <= '0;
      wvalid_r      <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr_r    <= start_addr;
        bytes_rem <= transfer_length;
      end
      if (state == ISSUE_WRITE && m_axi_awready) begin
        len_r         <= m_axi_awlen;
        span_r        <= AXI_ADDR_WIDTH'(span_c);
        burst_bytes_r <= burst_bytes_c;
        burst_left    <= burst_bytes_c;
        beat_cnt      <= '0;
        word_cnt      <= '0;
        pack_r        <= '0;
        strb_r        <= '0;
      end
      if (accept) begin
        pack_r[word_cnt*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= s_axis_tdata;
        strb_r[word_cnt*WORD_BYTES +: WORD_BYTES]           <= '1;
        burst_left <= burst_left - 32'(WORD_BYTES);
        word_cnt   <= beat_close ? '0 : word_cnt + 1'b1;
        if (beat_close) wvalid_r <= 1'b1;
`ifdef AXI4_WRITE_DMA_TLAST_CHECK_EN
        if (s_axis_tlast != ((burst_left == 32'(WORD_BYTES)) && (burst_bytes_r == bytes_rem)))
          error_r <= 1'b1;
`endif
      end
      // The pack register is cleared on each beat handshake so a short final
      // beat carries zeros in its unfilled lanes.
      if (w_hs) begin
        wvalid_r <= 1'b0;
        pack_r   <= '0;
        strb_r   <= '0;
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (state == WAIT_RESP && m_axi_bvalid) begin
        if (m_axi_bresp != 2'b00) begin
          error_r <= 1'b1;
        end else begin
          bytes_rem <= rem_after;
          addr_r    <= addr_r + span_r;
        end
      end
      if (state == DONE_STATE && !start) error_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_write_dma.sv
// Directed bench for axi4_write_dma: a table of transfers driven through an
// AXI slave / AXI-Stream source model, plus a mid-burst reset sequence.
module tb_axi4_write_dma;

  logic         aclk, areset;
  logic [63:0]  start_addr;
  logic [31:0]  transfer_length;
  logic         start, done, error;
  logic [0:0]   awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic [3:0]   awqos;
  logic         awvalid, awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [0:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [31:0]  tdata;
  logic         tvalid, tlast, tready;

  axi4_write_dma #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(128), .AXI_ID_WIDTH(1),
    .AXIS_DATA_WIDTH(32), .MAX_BURST_LEN(256)
  ) dut (
    .aclk(aclk), .areset(areset),
    .start_addr(start_addr), .transfer_length(transfer_length),
    .start(start), .done(done), .error(error),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
    .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int t, input int i);
    return (32'(t) << 24) | 32'(i);
  endfunction

  // Slave / source model state, configured per transfer by the test.
  int          nwords, word_idx, tag;
  logic [1:0]  first_bresp;
  bit          stall;
  int          aw_cnt, b_issued, b_done_cnt, pending_b, beats_seen, beat_in_burst;
  int          cur_beats;
  int          first_awlen;
  longint      model_rem;
  logic [63:0] base_addr;
  bit          bhs, ths;

  // Observe handshakes mid-cycle, then drive responses just after the edge.
  initial begin
    logic [127:0] ed;
    logic [15:0]  es;
    int           idx;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    tvalid = 1'b0; tdata = '0; tlast = 1'b0;
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (awvalid && awready) begin
          cur_beats = int'((model_rem + 15) / 16);
          if (cur_beats > 256) cur_beats = 256;
          if (aw_cnt == 0) first_awlen = int'(awlen);
          chk("aw_addr", awaddr, base_addr + 64'(aw_cnt) * 64'd4096);
          chk("aw_len", awlen, cur_beats - 1);
          chk("aw_fields", {awsize, awburst, awcache, awid, awlock, awprot, awqos},
              {3'd4, 2'b01, 4'b0011, 1'b0, 1'b0, 3'd0, 4'd0});
          chk("aw_after_prev_b", b_done_cnt, aw_cnt);
          model_rem = model_rem - ((longint'(cur_beats) * 16 > model_rem) ? model_rem
                                                                          : longint'(cur_beats) * 16);
          aw_cnt++;
          beat_in_burst = 0;
        end
        if (wvalid && wready) begin
          ed = '0;
          es = '0;
          for (int j = 0; j < 4; j++) begin
            idx = beats_seen * 4 + j;
            if (idx < nwords) begin
              ed[j*32 +: 32] = word_of(tag, idx);
              es[j*4 +: 4]   = 4'hF;
            end
          end
          chk("w_data", wdata, ed);
          chk("w_strb", wstrb, es);
          chk("w_last", wlast, beat_in_burst == cur_beats - 1);
          if (wlast) pending_b++;
          beats_seen++;
          beat_in_burst++;
        end
        if (bvalid && bready) begin
          b_done_cnt++;
          bhs = 1'b1;
        end
        if (tvalid && tready) begin
          word_idx++;
          ths = 1'b1;
        end
      end
      @(posedge aclk);
      #1;
      if (areset) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; tvalid = 1'b0;
        bhs = 1'b0; ths = 1'b0;
      end else begin
        awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        wready  = stall ? ($urandom_range(0, 1) == 0) : 1'b1;
        if (bhs) begin
          bvalid = 1'b0;
          bhs = 1'b0;
        end
        if (!bvalid && pending_b > 0 && (!stall || $urandom_range(0, 2) == 0)) begin
          bvalid = 1'b1;
          bresp  = (b_issued == 0) ? first_bresp : 2'b00;
          b_issued++;
          pending_b--;
        end
        if (ths || !tvalid) begin
          ths = 1'b0;
          if (word_idx < nwords && (!stall || $urandom_range(0, 1) == 0)) begin
            tvalid = 1'b1;
            tdata  = word_of(tag, word_idx);
            tlast  = (word_idx == nwords - 1);
          end else begin
            tvalid = 1'b0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [63:0] addr;
    int          len;
    logic [1:0]  bresp;
    bit          stall;
    logic        exp_err;
    int          exp_aw;
    int          exp_awlen0;
    int          exp_beats;
    int          exp_words;
  } xfer_t;

  task automatic setup_model(input xfer_t v, input int t);
    @(posedge aclk);
    #3;
    nwords = v.len / 4; word_idx = 0; tag = t; first_bresp = v.bresp; stall = v.stall;
    aw_cnt = 0; b_issued = 0; b_done_cnt = 0; pending_b = 0; beats_seen = 0;
    beat_in_burst = 0; cur_beats = 0; first_awlen = 0; model_rem = longint'(v.len);
    base_addr = v.addr; bhs = 1'b0; ths = 1'b0; tvalid = 1'b0; bvalid = 1'b0;
    start_addr = v.addr; transfer_length = 32'(v.len); start = 1'b1;
  endtask

  task automatic run_xfer(input xfer_t v, input int t);
    bit got;
    setup_model(v, t);
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge aclk);
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1'b1);
    chk("error", error, v.exp_err);
    chk("tready_in_done", tready, 1'b0);
    chk("aw_count", aw_cnt, v.exp_aw);
    chk("awlen_first", first_awlen, v.exp_awlen0);
    chk("beat_count", beats_seen, v.exp_beats);
    chk("word_count", word_idx, v.exp_words);
    chk("b_count", b_done_cnt, v.exp_aw);
    @(posedge aclk);
    #3;
    start = 1'b0;
    repeat (2) @(negedge aclk);
    chk("done_cleared", {done, error}, 2'b00);
  endtask

  xfer_t vec[8];

  initial begin
    bit got;
    vec[0] = '{64'h1000, 64,   2'b00, 1'b0, 1'b0, 1, 3,   4,   16};
    vec[1] = '{64'h0,    8192, 2'b00, 1'b0, 1'b0, 2, 255, 512, 2048};
    vec[2] = '{64'h2000, 40,   2'b00, 1'b0, 1'b0, 1, 2,   3,   10};
    vec[3] = '{64'h0,    8192, 2'b10, 1'b0, 1'b1, 1, 255, 256, 1024};
    vec[4] = '{64'h3000, 256,  2'b00, 1'b1, 1'b0, 1, 15,  16,  64};
    vec[5] = '{64'h4000, 0,    2'b00, 1'b0, 1'b0, 0, 0,   0,   0};
    vec[6] = '{64'h10,   4,    2'b00, 1'b0, 1'b0, 1, 0,   1,   1};
    vec[7] = '{64'h8000, 4100, 2'b00, 1'b1, 1'b0, 2, 255, 257, 1025};

    nwords = 0; word_idx = 0; stall = 1'b0; pending_b = 0;
    areset = 1'b1; start = 1'b0; start_addr = '0; transfer_length = '0;
    repeat (2) @(negedge aclk);
    chk("reset_ctrl", {awvalid, wvalid, wlast, bready, tready, done, error}, 7'd0);
    chk("reset_wdata", {wdata, wstrb}, '0);
    @(posedge aclk);
    #3;
    areset = 1'b0;

    for (int i = 0; i < 8; i++) run_xfer(vec[i], i + 1);

    // Reset while the second beat of a 4-beat burst is being packed.
    setup_model('{64'h1000, 64, 2'b00, 1'b0, 1'b0, 1, 3, 4, 16}, 20);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge aclk);
      if (beats_seen >= 1) got = 1'b1;
    end
    chk("first_beat_before_reset", got, 1'b1);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    chk("async_reset_ctrl", {awvalid, wvalid, wlast, bready, tready, done, error}, 7'd0);
    @(negedge aclk);
    start = 1'b0;
    nwords = 0;
    chk("reset_mid_ctrl", {awvalid, wvalid, wlast, bready, tready, done, error}, 7'd0);
    chk("reset_mid_wdata", {wdata, wstrb}, '0);
    @(posedge aclk);
    #3;
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    chk("idle_after_reset", {awvalid, wvalid, tready, done}, 4'd0);
    run_xfer('{64'h5000, 16, 2'b00, 1'b0, 1'b0, 1, 0, 1, 4}, 21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
